// File: rtl/dco_freq_cal.sv
// Closed-loop DCO coarse-code calibration: SAR search over the coarse code, then
// optional +/-1 drift tracking with a hysteresis dead-band.
module dco_freq_cal #(
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned HYST       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              track_en,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  target,
  input  logic              dco_tick,
  output logic [CODE_W-1:0] coarse_code,
  output logic              dco_clk_en,
  output logic              busy,
  output logic              locked,
  output logic [CNT_W-1:0]  meas_cnt,
  output logic              meas_valid,
  output logic              sat_err
);

  localparam int unsigned BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_DECIDE  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [CODE_W-1:0] CODE_MID    = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_MAX    = '1;
  localparam logic [WIN_W-1:0]  SETTLE_LOAD = WIN_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W:0]    HYST_X      = (CNT_W + 1)'(HYST);

  logic [2:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              track_q, track_d;
  logic [WIN_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CODE_W-1:0] code_d, code_tmp;
  logic [CNT_W-1:0]  meas_cnt_d;
  logic              meas_valid_d, busy_d, locked_d, clk_en_d, sat_d;
  logic [CNT_W:0]    cnt_x, tgt_x;

  // Widened by one bit so target+HYST cannot wrap.
  assign cnt_x = {1'b0, cnt_q};
  assign tgt_x = {1'b0, tgt_q};

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    track_d      = track_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    win_d        = win_q;
    code_d       = coarse_code;
    code_tmp     = coarse_code;
    meas_cnt_d   = meas_cnt;
    meas_valid_d = 1'b0;
    busy_d       = busy;
    locked_d     = locked;
    clk_en_d     = dco_clk_en;
    sat_d        = sat_err;

    if (abort) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      locked_d = 1'b0;
      clk_en_d = 1'b0;
      track_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            tgt_d    = target;
            win_d    = win_len;
            bit_d    = BIT_W'(CODE_W - 1);
            code_d   = CODE_MID;
            clk_en_d = 1'b1;
            busy_d   = 1'b1;
            locked_d = 1'b0;
            sat_d    = 1'b0;
            track_d  = 1'b0;
            tmr_d    = SETTLE_LOAD;
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == '0) begin
            // A zero-length window behaves as one cycle.
            tmr_d   = (win_q == '0) ? '0 : win_q - WIN_W'(1);
            cnt_d   = '0;
            state_d = ST_MEASURE;
          end else begin
            tmr_d = tmr_q - WIN_W'(1);
          end
        end
        ST_MEASURE: begin
          if (dco_tick && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          if (tmr_q == '0) state_d = ST_DECIDE;
          else             tmr_d   = tmr_q - WIN_W'(1);
        end
        ST_DECIDE: begin
          meas_cnt_d   = cnt_q;
          meas_valid_d = 1'b1;
          tmr_d        = SETTLE_LOAD;
          if (!track_q) begin
            if (cnt_x > tgt_x) code_tmp[bit_q] = 1'b0;
            if (bit_q != '0) begin
              code_tmp[bit_q - BIT_W'(1)] = 1'b1;
              bit_d   = bit_q - BIT_W'(1);
              state_d = ST_SETTLE;
            end else begin
              locked_d = 1'b1;
              if (track_en) begin
                track_d = 1'b1;
                state_d = ST_SETTLE;
              end else begin
                busy_d  = 1'b0;
                state_d = ST_DONE;
              end
            end
            code_d = code_tmp;
          end else begin
            if (cnt_x > tgt_x + HYST_X) begin
              if (coarse_code == '0) sat_d  = 1'b1;
              else                   code_d = coarse_code - CODE_W'(1);
            end else if (cnt_x + HYST_X < tgt_x) begin
              if (coarse_code == CODE_MAX) sat_d  = 1'b1;
              else                         code_d = coarse_code + CODE_W'(1);
            end
            if (track_en) begin
              state_d = ST_SETTLE;
            end else begin
              track_d = 1'b0;
              busy_d  = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      track_q     <= 1'b0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      tgt_q       <= '0;
      win_q       <= '0;
      coarse_code <= CODE_MID;
      meas_cnt    <= '0;
      meas_valid  <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      dco_clk_en  <= 1'b0;
      sat_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      track_q     <= track_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      win_q       <= win_d;
      coarse_code <= code_d;
      meas_cnt    <= meas_cnt_d;
      meas_valid  <= meas_valid_d;
      busy        <= busy_d;
      locked      <= locked_d;
      dco_clk_en  <= clk_en_d;
      sat_err     <= sat_d;
    end
  end

endmodule

// File: tb/tb_dco_freq_cal.sv
// Directed bench for dco_freq_cal: a phase-accumulator DCO model gives exactly
// k*code ticks per 100-cycle window; a narrow second instance covers count saturation.
module tb_dco_freq_cal;

  logic        clk = 1'b0;
  logic        rst, start, abort, track_en, dco_tick;
  logic [15:0] win_len, target;
  logic [3:0]  coarse_code;
  logic        dco_clk_en, busy, locked, meas_valid, sat_err;
  logic [15:0] meas_cnt;

  logic       s_start, s_abort, s_track_en;
  logic [7:0] s_win_len;
  logic [3:0] s_target, s_meas_cnt;
  logic [1:0] s_code;
  logic       s_clk_en, s_busy, s_locked, s_meas_valid, s_sat_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k = 10;
  int acc = 0;
  bit force_tick = 1'b0;

  dco_freq_cal dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .track_en(track_en),
    .win_len(win_len), .target(target), .dco_tick(dco_tick),
    .coarse_code(coarse_code), .dco_clk_en(dco_clk_en), .busy(busy), .locked(locked),
    .meas_cnt(meas_cnt), .meas_valid(meas_valid), .sat_err(sat_err)
  );

  dco_freq_cal #(.CODE_W(2), .CNT_W(4), .WIN_W(8), .SETTLE_CYC(2), .HYST(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .track_en(s_track_en),
    .win_len(s_win_len), .target(s_target), .dco_tick(dco_tick),
    .coarse_code(s_code), .dco_clk_en(s_clk_en), .busy(s_busy), .locked(s_locked),
    .meas_cnt(s_meas_cnt), .meas_valid(s_meas_valid), .sat_err(s_sat_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DCO model: k*code ticks per 100 cycles, exact over any window at constant code
  always @(negedge clk) begin
    if (force_tick) begin
      dco_tick = 1'b1;
    end else begin
      acc = acc + k * int'(coarse_code);
      if (acc >= 100) begin
        acc = acc - 100;
        dco_tick = 1'b1;
      end else begin
        dco_tick = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (coarse_code !== 4'd8) begin failures++; $display("FAIL reset_code got=%0d exp=8", coarse_code); end
    checks++; if (meas_cnt !== 16'd0) begin failures++; $display("FAIL reset_meas got=%0d exp=0", meas_cnt); end
    checks++; if ({busy, locked, dco_clk_en, meas_valid, sat_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {busy, locked, dco_clk_en, meas_valid, sat_err}); end
    checks++; if (s_code !== 2'b10) begin failures++; $display("FAIL reset_code_s got=%0d exp=2", s_code); end
  endtask

  task automatic test_search();
    int exp_m[4] = '{80, 40, 60, 70};
    int exp_c[4] = '{4, 6, 7, 7};
    int t0;
    bit got;
    k = 10; win_len = 16'd100; target = 16'd73; track_en = 1'b0;
    pulse_start();
    t0 = cyc;
    checks++; if ({coarse_code, busy, dco_clk_en} !== {4'd8, 2'b11}) begin
      failures++; $display("FAIL search_start got=%h exp=%h", {coarse_code, busy, dco_clk_en}, {4'd8, 2'b11}); end
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
      checks++; if (!got) begin failures++; $display("FAIL search_timeout step=%0d", i); end
      checks++; if (cyc - t0 != 109 * (i + 1)) begin failures++; $display("FAIL search_latency step=%0d got=%0d exp=%0d", i, cyc - t0, 109 * (i + 1)); end
      checks++; if (meas_cnt !== 16'(exp_m[i])) begin failures++; $display("FAIL search_meas step=%0d got=%0d exp=%0d", i, meas_cnt, exp_m[i]); end
      checks++; if (coarse_code !== 4'(exp_c[i])) begin failures++; $display("FAIL search_code step=%0d got=%0d exp=%0d", i, coarse_code, exp_c[i]); end
      checks++; if (locked !== (i == 3)) begin failures++; $display("FAIL search_locked step=%0d got=%b", i, locked); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL search_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_tracking();
    int exp_m[3] = '{84, 72, 72};
    bit got;
    k = 10; win_len = 16'd100; target = 16'd73; track_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
    end
    checks++; if ({coarse_code, locked, busy} !== {4'd7, 2'b11}) begin
      failures++; $display("FAIL track_lock got=%h exp=%h", {coarse_code, locked, busy}, {4'd7, 2'b11}); end
    k = 12;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) track_en = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
      checks++; if (!got) begin failures++; $display("FAIL track_timeout step=%0d", i); end
      checks++; if (meas_cnt !== 16'(exp_m[i])) begin failures++; $display("FAIL track_meas step=%0d got=%0d exp=%0d", i, meas_cnt, exp_m[i]); end
      checks++; if (coarse_code !== 4'd6) begin failures++; $display("FAIL track_code step=%0d got=%0d exp=6", i, coarse_code); end
    end
    checks++; if ({busy, locked, sat_err} !== 3'b010) begin failures++; $display("FAIL track_done got=%b exp=010", {busy, locked, sat_err}); end
  endtask

  task automatic test_saturation();
    bit got;
    k = 1; win_len = 16'd100; target = 16'd1000; track_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
    end
    checks++; if ({coarse_code, sat_err, locked} !== {4'd15, 2'b01}) begin
      failures++; $display("FAIL sat_search got=%h exp=%h", {coarse_code, sat_err, locked}, {4'd15, 2'b01}); end
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
    checks++; if ({got, coarse_code, sat_err} !== {1'b1, 4'd15, 1'b1}) begin
      failures++; $display("FAIL sat_track got=%h exp=%h", {got, coarse_code, sat_err}, {1'b1, 4'd15, 1'b1}); end
    track_en = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    bit got;
    k = 10; win_len = 16'd100; target = 16'd73; track_en = 1'b0;
    pulse_start();
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
    repeat (30) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({busy, dco_clk_en, locked} !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b exp=000", {busy, dco_clk_en, locked}); end
    checks++; if ({coarse_code, meas_cnt} !== {4'd4, 16'd80}) begin
      failures++; $display("FAIL abort_hold code=%0d meas=%0d exp code=4 meas=80", coarse_code, meas_cnt); end
    @(negedge clk) begin abort = 1'b1; start = 1'b1; end
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checks++; if ({busy, coarse_code} !== {1'b0, 4'd4}) begin
      failures++; $display("FAIL abort_priority busy=%b code=%0d exp busy=0 code=4", busy, coarse_code); end
    pulse_start();
    checks++; if ({busy, coarse_code} !== {1'b1, 4'd8}) begin
      failures++; $display("FAIL abort_restart busy=%b code=%0d exp busy=1 code=8", busy, coarse_code); end
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
    checks++; if ({got, meas_cnt, coarse_code} !== {1'b1, 16'd80, 4'd4}) begin
      failures++; $display("FAIL abort_rerun got=%0d meas=%0d code=%0d", got, meas_cnt, coarse_code); end
  endtask

  task automatic test_reset_mid();
    int exp_m[4] = '{80, 40, 60, 70};
    int t0;
    bit got;
    k = 10; win_len = 16'd100; target = 16'd73; track_en = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if ({coarse_code, meas_cnt} !== {4'd8, 16'd0}) begin
      failures++; $display("FAIL rstmid_vals code=%0d meas=%0d exp code=8 meas=0", coarse_code, meas_cnt); end
    checks++; if ({busy, locked, dco_clk_en, meas_valid, sat_err} !== 5'b0) begin
      failures++; $display("FAIL rstmid_flags got=%b exp=00000", {busy, locked, dco_clk_en, meas_valid, sat_err}); end
    @(negedge clk) rst = 1'b0;
    pulse_start();
    t0 = cyc;
    repeat (5) @(posedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
      checks++; if (cyc - t0 != 109 * (i + 1)) begin failures++; $display("FAIL busy_start_latency step=%0d got=%0d exp=%0d", i, cyc - t0, 109 * (i + 1)); end
      checks++; if (meas_cnt !== 16'(exp_m[i])) begin failures++; $display("FAIL busy_start_meas step=%0d got=%0d exp=%0d", i, meas_cnt, exp_m[i]); end
    end
  endtask

  task automatic test_win_zero();
    int t0;
    bit got;
    force_tick = 1'b1; win_len = 16'd0; target = 16'd0; track_en = 1'b0;
    pulse_start();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin @(posedge clk); #1; got = meas_valid; end
      checks++; if (cyc - t0 != 10 * (i + 1)) begin failures++; $display("FAIL win0_latency step=%0d got=%0d exp=%0d", i, cyc - t0, 10 * (i + 1)); end
      checks++; if (meas_cnt !== 16'd1) begin failures++; $display("FAIL win0_meas step=%0d got=%0d exp=1", i, meas_cnt); end
    end
    checks++; if ({coarse_code, locked} !== {4'd0, 1'b1}) begin
      failures++; $display("FAIL win0_final code=%0d locked=%b exp code=0 locked=1", coarse_code, locked); end
    s_win_len = 8'd20; s_target = 4'hF;
    @(negedge clk) s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    t0 = cyc;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin @(posedge clk); #1; got = s_meas_valid; end
    checks++; if (cyc - t0 != 23) begin failures++; $display("FAIL sat_cnt_latency got=%0d exp=23", cyc - t0); end
    checks++; if ({s_meas_cnt, s_code} !== {4'hF, 2'd3}) begin
      failures++; $display("FAIL sat_cnt meas=%0d code=%0d exp meas=15 code=3", s_meas_cnt, s_code); end
    force_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; track_en = 1'b0; dco_tick = 1'b0;
    win_len = 16'd100; target = 16'd73;
    s_start = 1'b0; s_abort = 1'b0; s_track_en = 1'b0; s_win_len = 8'd20; s_target = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst = 1'b0;
    test_search();
    test_tracking();
    test_saturation();
    test_abort();
    test_reset_mid();
    test_win_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
